// File: rtl/imem_port_arbiter.sv
// Shares one word-wide instruction memory port between the fetch stage (read-only)
// and the loader/debug port (read/write), one access per cycle, one-cycle responses.
module imem_port_arbiter #(
   parameter int ADDR_W    = 32,
   parameter int MEM_BYTES = 256
) (
   input  logic              del_clk,
   input  logic              rst_n,
   input  logic              fetch_req,
   input  logic [ADDR_W-1:0] fetch_addr,
   output logic              fetch_gnt,
   output logic              fetch_rvalid,
   output logic [31:0]       fetch_rdata,
   output logic              fetch_err,
   input  logic              ld_req,
   input  logic              ld_we,
   input  logic [ADDR_W-1:0] ld_addr,
   input  logic [31:0]       ld_wdata,
   input  logic              ld_lock,
   output logic              ld_gnt,
   output logic              ld_rvalid,
   output logic [31:0]       ld_rdata,
   output logic              ld_err,
   output logic              mem_en,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [31:0]       mem_wdata,
   input  logic [31:0]       mem_rdata
);

   typedef enum logic [1:0] {OWN_NONE, OWN_FETCH, OWN_LD} owner_e;
   typedef enum logic [1:0] {KIND_READ, KIND_WRITE, KIND_ERR} kind_e;
   typedef enum logic {LG_FETCH, LG_LD} grant_e;

   localparam logic [ADDR_W-1:0] MAX_ADDR = ADDR_W'(MEM_BYTES - 4);

   grant_e            last_grant_q;
   owner_e            rsp_owner_q, rsp_owner_d;
   kind_e             rsp_kind_q, rsp_kind_d;
   logic [31:0]       fetch_rdata_q, ld_rdata_q;
   logic              fetch_err_q, ld_err_q;
   logic [ADDR_W-1:0] sel_addr;
   logic              sel_legal;
   logic [31:0]       rsp_rdata;
   logic              rsp_err;

   function automatic logic addr_legal(input logic [ADDR_W-1:0] a);
      return (a[1:0] == 2'b00) && (a <= MAX_ADDR);
   endfunction

   always_comb begin
      fetch_gnt = 1'b0;
      ld_gnt    = 1'b0;
      if (rst_n) begin
         // A locked loader owns the port even when it is idle for a cycle.
         if (last_grant_q == LG_LD && ld_lock) begin
            ld_gnt = ld_req;
         end else if (fetch_req && ld_req) begin
            fetch_gnt = (last_grant_q == LG_LD);
            ld_gnt    = (last_grant_q == LG_FETCH);
         end else begin
            fetch_gnt = fetch_req;
            ld_gnt    = ld_req;
         end
      end
   end

   always_comb begin
      sel_addr  = ld_gnt ? ld_addr : fetch_addr;
      sel_legal = addr_legal(sel_addr);
      mem_en    = (fetch_gnt || ld_gnt) && sel_legal;
      mem_we    = mem_en && ld_gnt && ld_we;
      mem_addr  = sel_addr;
      mem_wdata = ld_wdata;

      rsp_owner_d = OWN_NONE;
      if (fetch_gnt)   rsp_owner_d = OWN_FETCH;
      else if (ld_gnt) rsp_owner_d = OWN_LD;

      rsp_kind_d = KIND_READ;
      if (!sel_legal)          rsp_kind_d = KIND_ERR;
      else if (ld_gnt && ld_we) rsp_kind_d = KIND_WRITE;
   end

   // Read data arrives from memory during the response cycle, so it is muxed
   // straight through then and held from the capture registers afterwards.
   always_comb begin
      rsp_rdata    = (rsp_kind_q == KIND_READ) ? mem_rdata : 32'h0;
      rsp_err      = (rsp_kind_q == KIND_ERR);
      fetch_rvalid = (rsp_owner_q == OWN_FETCH);
      ld_rvalid    = (rsp_owner_q == OWN_LD);
      fetch_rdata  = fetch_rvalid ? rsp_rdata : fetch_rdata_q;
      fetch_err    = fetch_rvalid ? rsp_err   : fetch_err_q;
      ld_rdata     = ld_rvalid    ? rsp_rdata : ld_rdata_q;
      ld_err       = ld_rvalid    ? rsp_err   : ld_err_q;
   end

   always_ff @(posedge del_clk or negedge rst_n) begin
      if (!rst_n) begin
         last_grant_q  <= LG_LD;
         rsp_owner_q   <= OWN_NONE;
         rsp_kind_q    <= KIND_READ;
         fetch_rdata_q <= 32'h0;
         fetch_err_q   <= 1'b0;
         ld_rdata_q    <= 32'h0;
         ld_err_q      <= 1'b0;
      end else begin
         if (ld_gnt)         last_grant_q <= LG_LD;
         else if (fetch_gnt) last_grant_q <= LG_FETCH;
         rsp_owner_q <= rsp_owner_d;
         rsp_kind_q  <= rsp_kind_d;
         if (fetch_rvalid) begin
            fetch_rdata_q <= rsp_rdata;
            fetch_err_q   <= rsp_err;
         end
         if (ld_rvalid) begin
            ld_rdata_q <= rsp_rdata;
            ld_err_q   <= rsp_err;
         end
      end
   end

endmodule

// File: tb/tb_imem_port_arbiter.sv
// Directed bench for imem_port_arbiter with a small behavioural instruction memory.
module tb_imem_port_arbiter;

   logic        del_clk = 1'b0;
   logic        rst_n;
   logic        fetch_req, ld_req, ld_we, ld_lock;
   logic [31:0] fetch_addr, ld_addr, ld_wdata;
   logic        fetch_gnt, fetch_rvalid, fetch_err;
   logic        ld_gnt, ld_rvalid, ld_err;
   logic [31:0] fetch_rdata, ld_rdata;
   logic        mem_en, mem_we;
   logic [31:0] mem_addr, mem_wdata, mem_rdata;

   int errors = 0;
   int checks = 0;

   always #5 del_clk = ~del_clk;

   imem_port_arbiter #(.ADDR_W(32), .MEM_BYTES(256)) dut (
      .del_clk(del_clk), .rst_n(rst_n),
      .fetch_req(fetch_req), .fetch_addr(fetch_addr), .fetch_gnt(fetch_gnt),
      .fetch_rvalid(fetch_rvalid), .fetch_rdata(fetch_rdata), .fetch_err(fetch_err),
      .ld_req(ld_req), .ld_we(ld_we), .ld_addr(ld_addr), .ld_wdata(ld_wdata),
      .ld_lock(ld_lock), .ld_gnt(ld_gnt), .ld_rvalid(ld_rvalid), .ld_rdata(ld_rdata),
      .ld_err(ld_err), .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
   );

   // Memory: unwritten words read as a fixed pattern, word 2 holds 0x00500093.
   logic [31:0] mem [64];
   logic [63:0] wr_mask = '0;
   always @(posedge del_clk) begin
      if (mem_en) begin
         if (mem_we) begin
            mem[mem_addr[7:2]]     <= mem_wdata;
            wr_mask[mem_addr[7:2]] <= 1'b1;
         end else if (wr_mask[mem_addr[7:2]]) begin
            mem_rdata <= mem[mem_addr[7:2]];
         end else if (mem_addr[7:2] == 6'd2) begin
            mem_rdata <= 32'h0050_0093;
         end else begin
            mem_rdata <= 32'hA000_0000 | {26'h0, mem_addr[7:2]};
         end
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic next_cyc();
      @(posedge del_clk);
      #1;
   endtask

   task automatic sample();
      @(negedge del_clk);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 1'b0; fetch_req = 1'b1; ld_req = 1'b1; ld_we = 1'b0; ld_lock = 1'b0;
      fetch_addr = 32'h8; ld_addr = 32'h10; ld_wdata = 32'h0;
      sample();
      chk("rst_fetch_gnt", fetch_gnt, 1'b0);
      chk("rst_ld_gnt", ld_gnt, 1'b0);
      chk("rst_mem_en", mem_en, 1'b0);
      chk("rst_fetch_rvalid", fetch_rvalid, 1'b0);
      chk("rst_ld_rvalid", ld_rvalid, 1'b0);
      chk("rst_fetch_rdata", fetch_rdata, 32'h0);
      next_cyc();
      rst_n = 1'b1; fetch_req = 1'b0; ld_req = 1'b0;

      // Single fetch read of 0x8.
      next_cyc();
      fetch_req = 1'b1; fetch_addr = 32'h8;
      sample();
      chk("f1_gnt", fetch_gnt, 1'b1);
      chk("f1_ld_gnt", ld_gnt, 1'b0);
      chk("f1_mem_en", mem_en, 1'b1);
      chk("f1_mem_we", mem_we, 1'b0);
      chk("f1_mem_addr", mem_addr, 32'h8);
      next_cyc();
      fetch_req = 1'b0;
      sample();
      chk("f1_rvalid", fetch_rvalid, 1'b1);
      chk("f1_rdata", fetch_rdata, 32'h0050_0093);
      chk("f1_err", fetch_err, 1'b0);
      chk("f1_ld_rvalid", ld_rvalid, 1'b0);
      next_cyc();
      sample();
      chk("f1_rvalid_pulse", fetch_rvalid, 1'b0);
      chk("f1_rdata_hold", fetch_rdata, 32'h0050_0093);

      // Fresh reset, then both requesters contend continuously.
      next_cyc();
      rst_n = 1'b0;
      next_cyc();
      rst_n = 1'b1;
      for (int i = 0; i < 4; i++) begin
         next_cyc();
         if (i == 0) begin
            fetch_req = 1'b1; fetch_addr = 32'h0;
            ld_req = 1'b1; ld_we = 1'b0; ld_addr = 32'h10;
         end
         sample();
         chk($sformatf("rr%0d_fetch_gnt", i), fetch_gnt, (i % 2 == 0));
         chk($sformatf("rr%0d_ld_gnt", i), ld_gnt, (i % 2 == 1));
         chk($sformatf("rr%0d_mem_addr", i), mem_addr, (i % 2 == 0) ? 32'h0 : 32'h10);
         if (i > 0 && (i % 2 == 1)) begin
            chk($sformatf("rr%0d_fetch_rvalid", i), fetch_rvalid, 1'b1);
            chk($sformatf("rr%0d_fetch_rdata", i), fetch_rdata, 32'hA000_0000);
            chk($sformatf("rr%0d_ld_rvalid", i), ld_rvalid, 1'b0);
         end else if (i > 0) begin
            chk($sformatf("rr%0d_ld_rvalid", i), ld_rvalid, 1'b1);
            chk($sformatf("rr%0d_ld_rdata", i), ld_rdata, 32'hA000_0004);
            chk($sformatf("rr%0d_fetch_rvalid", i), fetch_rvalid, 1'b0);
         end
      end

      // Loader held the last grant; lock keeps fetch out for four cycles.
      for (int i = 0; i < 4; i++) begin
         next_cyc();
         ld_lock = 1'b1;
         sample();
         chk($sformatf("lock%0d_fetch_gnt", i), fetch_gnt, 1'b0);
         chk($sformatf("lock%0d_ld_gnt", i), ld_gnt, 1'b1);
         chk($sformatf("lock%0d_ld_rvalid", i), ld_rvalid, 1'b1);
      end
      next_cyc();
      ld_lock = 1'b0;
      sample();
      chk("unlock_fetch_gnt", fetch_gnt, 1'b1);
      chk("unlock_ld_gnt", ld_gnt, 1'b0);
      next_cyc();
      fetch_req = 1'b0; ld_req = 1'b0;
      sample();
      chk("unlock_fetch_rvalid", fetch_rvalid, 1'b1);
      chk("unlock_ld_rvalid", ld_rvalid, 1'b0);

      // Loader write to the top word, then read it back.
      next_cyc();
      ld_req = 1'b1; ld_we = 1'b1; ld_addr = 32'hFC; ld_wdata = 32'hDEAD_BEEF;
      sample();
      chk("wr_ld_gnt", ld_gnt, 1'b1);
      chk("wr_mem_en", mem_en, 1'b1);
      chk("wr_mem_we", mem_we, 1'b1);
      chk("wr_mem_addr", mem_addr, 32'hFC);
      chk("wr_mem_wdata", mem_wdata, 32'hDEAD_BEEF);
      next_cyc();
      ld_we = 1'b0;
      sample();
      chk("wr_rvalid", ld_rvalid, 1'b1);
      chk("wr_err", ld_err, 1'b0);
      chk("wr_rdata", ld_rdata, 32'h0);
      chk("rd_ld_gnt", ld_gnt, 1'b1);
      chk("rd_mem_we", mem_we, 1'b0);
      next_cyc();
      ld_req = 1'b0;
      sample();
      chk("rd_rvalid", ld_rvalid, 1'b1);
      chk("rd_rdata", ld_rdata, 32'hDEAD_BEEF);
      chk("rd_err", ld_err, 1'b0);

      // Illegal addresses: misaligned, then one past the end.
      next_cyc();
      fetch_req = 1'b1; fetch_addr = 32'h6;
      sample();
      chk("mis_gnt", fetch_gnt, 1'b1);
      chk("mis_mem_en", mem_en, 1'b0);
      next_cyc();
      fetch_addr = 32'h100;
      sample();
      chk("mis_rvalid", fetch_rvalid, 1'b1);
      chk("mis_err", fetch_err, 1'b1);
      chk("mis_rdata", fetch_rdata, 32'h0);
      chk("oob_gnt", fetch_gnt, 1'b1);
      chk("oob_mem_en", mem_en, 1'b0);
      next_cyc();
      fetch_req = 1'b0;
      sample();
      chk("oob_rvalid", fetch_rvalid, 1'b1);
      chk("oob_err", fetch_err, 1'b1);
      chk("oob_rdata", fetch_rdata, 32'h0);
      next_cyc();
      ld_req = 1'b1; ld_we = 1'b1; ld_addr = 32'h100;
      sample();
      chk("ldoob_gnt", ld_gnt, 1'b1);
      chk("ldoob_mem_en", mem_en, 1'b0);
      chk("ldoob_mem_we", mem_we, 1'b0);
      chk("oob_err_hold", fetch_err, 1'b1);
      chk("oob_rvalid_pulse", fetch_rvalid, 1'b0);
      next_cyc();
      ld_req = 1'b0; ld_we = 1'b0;
      sample();
      chk("ldoob_rvalid", ld_rvalid, 1'b1);
      chk("ldoob_err", ld_err, 1'b1);
      chk("ldoob_rdata", ld_rdata, 32'h0);

      // Reset right after a fetch accept discards the response.
      next_cyc();
      fetch_req = 1'b1; fetch_addr = 32'h8;
      sample();
      chk("mid_gnt", fetch_gnt, 1'b1);
      next_cyc();
      fetch_req = 1'b0;
      rst_n = 1'b0;
      #1;
      chk("mid_fetch_rvalid", fetch_rvalid, 1'b0);
      chk("mid_fetch_rdata", fetch_rdata, 32'h0);
      chk("mid_fetch_err", fetch_err, 1'b0);
      chk("mid_ld_err", ld_err, 1'b0);
      chk("mid_ld_rvalid", ld_rvalid, 1'b0);
      next_cyc();
      rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         sample();
         chk($sformatf("post%0d_fetch_rvalid", i), fetch_rvalid, 1'b0);
         next_cyc();
      end
      fetch_req = 1'b1; fetch_addr = 32'h0;
      ld_req = 1'b1; ld_addr = 32'h10;
      sample();
      chk("post_fetch_gnt", fetch_gnt, 1'b1);
      chk("post_ld_gnt", ld_gnt, 1'b0);
      next_cyc();
      fetch_req = 1'b0; ld_req = 1'b0;
      sample();
      chk("post_fetch_rvalid", fetch_rvalid, 1'b1);
      chk("post_fetch_rdata", fetch_rdata, 32'hA000_0000);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/imem_port_arbiter.md
Name: imem_port_arbiter

Overview:
- Shares the single byte-addressed, word-wide instruction memory port between two requesters: the core fetch stage (read-only) and the program loader/debug port (read/write).
- Sits between the fetch unit and the loader on one side and the instruction memory on the other.
- Arbitrates one access per cycle, sequences the memory's one-cycle read latency, routes responses back to the requester, and rejects illegal addresses without touching memory.

Parameters:
- ADDR_W, 32, width of all address buses.
- MEM_BYTES, 256, memory size in bytes; legal word addresses are 0 to MEM_BYTES-4.

Ports:
- del_clk  in  1  sole clock; all state updates on posedge.
- rst_n  in  1  asynchronous, active-low reset.
- fetch_req  in  1  fetch read request.
- fetch_addr  in  ADDR_W  fetch byte address.
- fetch_gnt  out  1  request accepted this cycle (combinational).
- fetch_rvalid  out  1  response valid.
- fetch_rdata  out  32  instruction word.
- fetch_err  out  1  response is an error.
- ld_req  in  1  loader request.
- ld_we  in  1  1 = write, 0 = read.
- ld_addr  in  ADDR_W  loader byte address.
- ld_wdata  in  32  write data.
- ld_lock  in  1  hold arbitration for the loader while asserted.
- ld_gnt  out  1  request accepted this cycle (combinational).
- ld_rvalid  out  1  response valid.
- ld_rdata  out  32  read data (0 for writes and errors).
- ld_err  out  1  response is an error.
- mem_en  out  1  memory access strobe (combinational).
- mem_we  out  1  memory write enable.
- mem_addr  out  ADDR_W  memory byte address.
- mem_wdata  out  32  memory write data.
- mem_rdata  in  32  memory read data, valid in the cycle after a mem_en read.

Behaviour:
- Reset values:
  - Registered outputs fetch_rvalid, fetch_rdata, fetch_err, ld_rvalid, ld_rdata, ld_err all 0.
  - last_grant = LOADER, so fetch wins the first tie.
  - rsp_owner = NONE.
  - Combinational outputs fetch_gnt, ld_gnt, mem_en, mem_we are 0 while rst_n is low.
- Arbitration, evaluated combinationally every cycle:
  - Only one requester: that requester is granted.
  - Both requesting: the requester that was not last_grant is granted (round-robin).
  - Exception: if last_grant = LOADER and ld_lock = 1, the loader is granted whenever ld_req = 1, and fetch is blocked even if it requests alone.
  - last_grant updates on every grant.
- Handshake:
  - A request is accepted in the cycle its gnt is high. The requester must hold req/addr/data until gnt.
  - One access is accepted per cycle. Back-to-back accepts are allowed.
- Address check on the granted request:
  - Legal: addr[1:0] == 0 and addr <= MEM_BYTES-4.
  - Legal: mem_en = 1, mem_we = (granted is loader and ld_we), mem_addr = addr, mem_wdata = ld_wdata.
  - Illegal: gnt is still given and mem_en = 0. The response follows with err = 1 and rdata = 0.
  - Fetch writes do not exist. Loader writes get a response with rdata = 0 and err = 0 (or err = 1 if illegal).
- Latency:
  - Response appears exactly 1 cycle after acceptance, with {rvalid = 1, rdata, err} for that requester.
  - Read rdata = mem_rdata in the response cycle.
  - rvalid is a single-cycle pulse. The non-owner's rvalid stays 0.
  - Both requesters' rdata/err hold their last values when rvalid = 0.
- Response routing: the rsp_owner and rsp_kind (read / write / error) registers are captured at acceptance and consumed the next cycle.
- Reset mid-operation: an in-flight response is discarded. No rvalid is produced after rst_n deasserts, and arbitration restarts with fetch priority.
- Address wrap: addresses >= MEM_BYTES never wrap; they are errors. Address MEM_BYTES-4 is legal.

Test Plan:
- Reset, then fetch_req with fetch_addr = 0x8 -> same cycle: fetch_gnt = 1, mem_en = 1, mem_addr = 0x8. Next cycle: fetch_rvalid = 1 and fetch_rdata = mem_rdata (0x00500093). ld_rvalid stays 0.
- Both requesting continuously from reset (ld read at 0x10, fetch at 0x0) -> grants alternate F, L, F, L. Each rvalid arrives one cycle after its grant, one response per cycle.
- Loader wins a grant, then holds ld_lock = 1 with ld_req = 1 for 4 cycles while fetch_req = 1 -> fetch_gnt = 0 for those 4 cycles. After ld_lock drops, fetch is granted next.
- Loader write ld_addr = 0xFC, ld_wdata = 0xDEADBEEF -> mem_we = 1, mem_addr = 0xFC. Next cycle ld_rvalid = 1, ld_err = 0. A following loader read of 0xFC returns 0xDEADBEEF.
- fetch_addr = 0x6 (misaligned), then 0x100 (MEM_BYTES) -> fetch_gnt = 1 and mem_en = 0 each time. Next cycle fetch_rvalid = 1, fetch_err = 1, fetch_rdata = 0.
- Assert rst_n low the cycle after a fetch accept -> no fetch_rvalid ever appears for it. All registered outputs are 0 immediately, asynchronously.
